// File: rtl/ps2_pkg.sv
// Shared constants, state encodings and event layout for the PS/2 key scheduler.
package ps2_pkg;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  // Event word layout: {ext, brk, code[7:0]}
  localparam int unsigned EV_W        = 10;
  localparam int unsigned EV_CODE_LSB = 0;
  localparam int unsigned EV_BRK_BIT  = 8;
  localparam int unsigned EV_EXT_BIT  = 9;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_A    = 2'd1;
  localparam logic [1:0] WIN_B    = 2'd2;

  typedef enum logic [1:0] {
    D_IDLE    = 2'd0,
    D_EXT     = 2'd1,
    D_BRK     = 2'd2,
    D_EXT_BRK = 2'd3
  } dec_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_ARMED = 2'd1,
    R_GO    = 2'd2,
    R_DONE  = 2'd3
  } round_state_e;

endpackage

// File: rtl/ps2_key_scheduler_if.sv
// Byte input, round control and event output bundle of the key scheduler.
interface ps2_key_scheduler_if;
  import ps2_pkg::*;

  logic            byte_valid;
  logic [7:0]      byte_data;
  logic            frame_err;
  logic            arm;
  logic            go;
  logic            clr;
  logic [2:0]      key_down;
  logic [1:0]      round_state;
  logic [1:0]      winner;
  logic            foul;
  logic            ev_valid;
  logic [EV_W-1:0] ev_data;
  logic            ev_ready;
  logic            overflow;

  modport master (
    output byte_valid, byte_data, frame_err, arm, go, clr, ev_ready,
    input  key_down, round_state, winner, foul, ev_valid, ev_data, overflow
  );

  modport slave (
    input  byte_valid, byte_data, frame_err, arm, go, clr, ev_ready,
    output key_down, round_state, winner, foul, ev_valid, ev_data, overflow
  );

endinterface

// File: rtl/ps2_event_fifo.sv
// Synchronous event FIFO with registered head word and sticky drop-on-full flag.
module ps2_event_fifo #(
  parameter int unsigned W     = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  input  logic         clr_ovf,
  output logic [W-1:0] rdata,
  output logic         valid,
  output logic         overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  logic [W-1:0]  head_q;
  logic [W-1:0]  head_nxt;
  logic          valid_q;
  logic          ovf_q;
  logic          ovf_nxt;
  logic          full_c;
  logic          pop_c;
  logic          push_c;
  logic          drop_c;

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign full_c = (count_q == CW'(DEPTH));
  assign pop_c  = pop & valid_q;
  assign push_c = push & (~full_c | pop_c);
  assign drop_c = push & full_c & ~pop_c;

  // Next occupancy, next head word and overflow flag
  always_comb begin
    count_nxt = count_q;
    head_nxt  = head_q;
    ovf_nxt   = ovf_q;
    if (push_c && !pop_c) begin
      count_nxt = count_q + CW'(1);
    end else if (!push_c && pop_c) begin
      count_nxt = count_q - CW'(1);
    end
    if (push_c && ((count_q == CW'(0)) || (pop_c && (count_q == CW'(1))))) begin
      head_nxt = wdata;
    end else if (pop_c) begin
      head_nxt = mem[rd_ptr_q + AW'(1)];
    end
    if (clr_ovf) begin
      ovf_nxt = 1'b0;
    end else if (drop_c) begin
      ovf_nxt = 1'b1;
    end
  end

  // Pointer, occupancy and head registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_nxt;
      head_q  <= head_nxt;
      valid_q <= (count_nxt != CW'(0));
      ovf_q   <= ovf_nxt;
    end
  end

  // Storage array; contents are only meaningful behind valid pointers
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr_q] <= wdata;
  end

  assign rdata    = head_q;
  assign valid    = valid_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/ps2_key_scheduler.sv
// Scancode prefix decoder, held-key tracker with typematic suppression,
// standoff round arbiter and event queue for the game logic.
module ps2_key_scheduler
  import ps2_pkg::*;
#(
  parameter logic [7:0]  KEY_A      = 8'h1C,
  parameter logic [7:0]  KEY_B      = 8'h4B,
  parameter logic [7:0]  KEY_START  = 8'h29,
  parameter int unsigned TIMEOUT    = 100000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  ps2_key_scheduler_if.slave bus
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  dec_state_e      dec_q;
  dec_state_e      dec_nxt;
  logic [TW-1:0]   tmo_q;
  logic [TW-1:0]   tmo_nxt;
  logic            emit_c;
  logic            ev_ext_c;
  logic            ev_brk_c;
  logic [EV_W-1:0] ev_word_c;

  logic [2:0]      kd_q;
  logic [2:0]      kd_nxt;
  logic [2:0]      hit_c;
  logic            push_c;
  logic            press_a_q;
  logic            press_b_q;

  round_state_e    rs_q;
  round_state_e    rs_nxt;
  logic [1:0]      win_q;
  logic [1:0]      win_nxt;
  logic            foul_q;
  logic            foul_nxt;

  // Prefix decoder: E0 always restarts as extended, F0 adds break (or restarts a break)
  always_comb begin
    dec_nxt  = dec_q;
    tmo_nxt  = tmo_q;
    emit_c   = 1'b0;
    ev_ext_c = 1'b0;
    ev_brk_c = 1'b0;
    if (bus.byte_valid) begin
      tmo_nxt = '0;
    end else if (tmo_q != TW'(TIMEOUT)) begin
      tmo_nxt = tmo_q + TW'(1);
    end
    if (bus.frame_err) begin
      dec_nxt = D_IDLE;
    end else if (bus.byte_valid) begin
      if (bus.byte_data == SC_EXT) begin
        dec_nxt = D_EXT;
      end else if (bus.byte_data == SC_BRK) begin
        dec_nxt = (dec_q == D_EXT) ? D_EXT_BRK : D_BRK;
      end else begin
        emit_c   = 1'b1;
        ev_ext_c = (dec_q == D_EXT) || (dec_q == D_EXT_BRK);
        ev_brk_c = (dec_q == D_BRK) || (dec_q == D_EXT_BRK);
        dec_nxt  = D_IDLE;
      end
    end else if ((dec_q != D_IDLE) && (tmo_nxt == TW'(TIMEOUT))) begin
      dec_nxt = D_IDLE;
    end
  end

  // Event word assembly
  always_comb begin
    ev_word_c                       = '0;
    ev_word_c[EV_EXT_BIT]           = ev_ext_c;
    ev_word_c[EV_BRK_BIT]           = ev_brk_c;
    ev_word_c[EV_CODE_LSB +: 8]     = bus.byte_data;
  end

  // Held-key tracking; a make on a key already down is dropped entirely
  always_comb begin
    hit_c  = {bus.byte_data == KEY_START, bus.byte_data == KEY_B, bus.byte_data == KEY_A}
             & {3{emit_c & ~ev_ext_c}};
    kd_nxt = kd_q;
    push_c = emit_c;
    if (ev_brk_c) begin
      kd_nxt = kd_q & ~hit_c;
    end else begin
      kd_nxt = kd_q | hit_c;
      if ((hit_c & kd_q) != 3'b000) push_c = 1'b0;
    end
  end

  // Round arbiter: false start in ARMED hands the win to the other player
  always_comb begin
    rs_nxt   = rs_q;
    win_nxt  = win_q;
    foul_nxt = foul_q;
    if (bus.clr) begin
      rs_nxt   = R_IDLE;
      win_nxt  = WIN_NONE;
      foul_nxt = 1'b0;
    end else begin
      case (rs_q)
        R_IDLE: begin
          if (bus.arm) rs_nxt = R_ARMED;
        end
        R_ARMED: begin
          if (press_a_q) begin
            rs_nxt   = R_DONE;
            win_nxt  = WIN_B;
            foul_nxt = 1'b1;
          end else if (press_b_q) begin
            rs_nxt   = R_DONE;
            win_nxt  = WIN_A;
            foul_nxt = 1'b1;
          end else if (bus.go) begin
            rs_nxt = R_GO;
          end
        end
        R_GO: begin
          if (press_a_q) begin
            rs_nxt  = R_DONE;
            win_nxt = WIN_A;
          end else if (press_b_q) begin
            rs_nxt  = R_DONE;
            win_nxt = WIN_B;
          end
        end
        default: begin
          rs_nxt = R_DONE;
        end
      endcase
    end
  end

  // State registers for decoder, tracker and round
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q     <= D_IDLE;
      tmo_q     <= '0;
      kd_q      <= '0;
      press_a_q <= 1'b0;
      press_b_q <= 1'b0;
      rs_q      <= R_IDLE;
      win_q     <= WIN_NONE;
      foul_q    <= 1'b0;
    end else begin
      dec_q     <= dec_nxt;
      tmo_q     <= tmo_nxt;
      kd_q      <= kd_nxt;
      press_a_q <= kd_nxt[0] & ~kd_q[0];
      press_b_q <= kd_nxt[1] & ~kd_q[1];
      rs_q      <= rs_nxt;
      win_q     <= win_nxt;
      foul_q    <= foul_nxt;
    end
  end

  ps2_event_fifo #(
    .W     (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_c),
    .wdata    (ev_word_c),
    .pop      (bus.ev_ready),
    .clr_ovf  (bus.clr),
    .rdata    (bus.ev_data),
    .valid    (bus.ev_valid),
    .overflow (bus.overflow)
  );

  assign bus.key_down    = kd_q;
  assign bus.round_state = rs_q;
  assign bus.winner      = win_q;
  assign bus.foul        = foul_q;

endmodule

// File: tb/tb_ps2_key_scheduler.sv
// Randomised and directed bench for ps2_key_scheduler against a behavioural model.
module tb_ps2_key_scheduler;
  import ps2_pkg::*;

  localparam int TMO   = 20;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  ps2_key_scheduler_if bus_if ();

  ps2_key_scheduler #(.TIMEOUT(TMO), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [9:0] m_q[$];
  logic       m_pfx_ext, m_pfx_brk;
  int         m_gap;
  logic [2:0] m_held;
  int         m_round, m_win, m_press;
  logic       m_foul, m_ovf;

  task automatic model_reset();
    m_q.delete();
    m_pfx_ext = 0; m_pfx_brk = 0; m_gap = 0;
    m_held = 0; m_round = 0; m_win = 0; m_press = 0;
    m_foul = 0; m_ovf = 0;
  endtask

  function automatic int key_idx(input logic [7:0] c);
    if (c == 8'h1C) return 0;
    if (c == 8'h4B) return 1;
    if (c == 8'h29) return 2;
    return -1;
  endfunction

  // Advance the model by one clock edge using the inputs that edge will sample
  task automatic model_step();
    logic       have_ev;
    logic [9:0] ev;
    logic       do_push;
    int         idx;
    // round reacts to the press registered on the previous edge
    if (bus_if.clr) begin
      m_round = 0; m_win = 0; m_foul = 0;
    end else if (m_round == 1) begin
      if (m_press != 0) begin m_round = 3; m_foul = 1; m_win = (m_press == 1) ? 2 : 1; end
      else if (bus_if.go) m_round = 2;
    end else if (m_round == 2) begin
      if (m_press != 0) begin m_round = 3; m_win = m_press; end
    end else if (m_round == 0) begin
      if (bus_if.arm) m_round = 1;
    end
    m_press = 0;
    if (bus_if.ev_ready && m_q.size() > 0) void'(m_q.pop_front());
    if (bus_if.clr) m_ovf = 0;
    have_ev = 0;
    ev = '0;
    if (bus_if.frame_err) begin
      m_pfx_ext = 0; m_pfx_brk = 0;
    end else if (bus_if.byte_valid) begin
      if (bus_if.byte_data == 8'hE0) begin
        m_pfx_ext = 1; m_pfx_brk = 0;
      end else if (bus_if.byte_data == 8'hF0) begin
        if (m_pfx_brk) m_pfx_ext = 0;
        m_pfx_brk = 1;
      end else begin
        have_ev = 1;
        ev[EV_EXT_BIT] = m_pfx_ext;
        ev[EV_BRK_BIT] = m_pfx_brk;
        ev[7:0] = bus_if.byte_data;
        m_pfx_ext = 0; m_pfx_brk = 0;
      end
    end
    if (bus_if.byte_valid) m_gap = 0;
    else begin
      m_gap++;
      if (m_gap >= TMO) begin m_pfx_ext = 0; m_pfx_brk = 0; end
    end
    if (have_ev) begin
      do_push = 1;
      idx = key_idx(ev[7:0]);
      if (!ev[EV_EXT_BIT] && idx >= 0) begin
        if (ev[EV_BRK_BIT]) m_held[idx] = 0;
        else if (m_held[idx]) do_push = 0;
        else begin
          m_held[idx] = 1;
          if (idx < 2) m_press = idx + 1;
        end
      end
      if (do_push) begin
        if (m_q.size() < DEPTH) m_q.push_back(ev);
        else if (!bus_if.clr) m_ovf = 1;
      end
    end
  endtask

  // Compare on the falling edge, then advance the model for the next rising edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      else begin
        chk("key_down", bus_if.key_down, m_held);
        chk("round_state", bus_if.round_state, m_round);
        chk("winner", bus_if.winner, m_win);
        chk("foul", bus_if.foul, m_foul);
        chk("overflow", bus_if.overflow, m_ovf);
        chk("ev_valid", bus_if.ev_valid, m_q.size() > 0);
        if (m_q.size() > 0) chk("ev_data", bus_if.ev_data, m_q[0]);
        model_step();
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.byte_valid = 0; bus_if.byte_data = 8'h00; bus_if.frame_err = 0;
    bus_if.arm = 0; bus_if.go = 0; bus_if.clr = 0; bus_if.ev_ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    #2;
    chk("rst_key_down", bus_if.key_down, 3'b000);
    chk("rst_ev_valid", bus_if.ev_valid, 1'b0);
    chk("rst_round", bus_if.round_state, 2'd0);
    chk("rst_overflow", bus_if.overflow, 1'b0);
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus_if.byte_valid = 1;
    bus_if.byte_data  = b;
    tick();
    bus_if.byte_valid = 0;
  endtask

  task automatic pulse_arm(); bus_if.arm = 1; tick(); bus_if.arm = 0; endtask
  task automatic pulse_go();  bus_if.go  = 1; tick(); bus_if.go  = 0; endtask
  task automatic pulse_clr(); bus_if.clr = 1; tick(); bus_if.clr = 0; endtask

  task automatic pop_expect(input string name, input logic [9:0] exp);
    chk({name, "_valid"}, bus_if.ev_valid, 1'b1);
    chk({name, "_data"}, bus_if.ev_data, exp);
    bus_if.ev_ready = 1;
    tick();
    bus_if.ev_ready = 0;
  endtask

  function automatic logic [7:0] pick_byte();
    int r;
    r = $urandom_range(0, 15);
    if (r <= 2) return 8'hE0;
    if (r <= 5) return 8'hF0;
    if (r <= 7) return 8'h1C;
    if (r <= 9) return 8'h4B;
    if (r == 10) return 8'h29;
    if (r == 11) return 8'h75;
    return 8'($urandom);
  endfunction

  initial begin
    int rdy_pct;
    rst_n = 0;
    idle_inputs();
    do_reset();

    // make then break of player A
    send_byte(8'h1C);
    chk("t1_kd_make", bus_if.key_down, 3'b001);
    chk("t1_head", bus_if.ev_data, 10'h01C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    chk("t1_kd_break", bus_if.key_down, 3'b000);
    pop_expect("t1_ev0", 10'h01C);
    pop_expect("t1_ev1", 10'h11C);
    chk("t1_empty", bus_if.ev_valid, 1'b0);

    // extended break
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    chk("t2_kd", bus_if.key_down, 3'b000);
    pop_expect("t2_ev", 10'h375);
    chk("t2_empty", bus_if.ev_valid, 1'b0);

    // fair win by B, later A press ignored
    do_reset();
    pulse_arm();
    chk("t3_armed", bus_if.round_state, 2'd1);
    pulse_go();
    chk("t3_go", bus_if.round_state, 2'd2);
    send_byte(8'h4B);
    chk("t3_n1_round", bus_if.round_state, 2'd2);
    tick();
    chk("t3_winner", bus_if.winner, 2'd2);
    chk("t3_foul", bus_if.foul, 1'b0);
    chk("t3_done", bus_if.round_state, 2'd3);
    send_byte(8'h1C);
    tick();
    chk("t3_winner_hold", bus_if.winner, 2'd2);

    // false start by A
    do_reset();
    pulse_arm();
    send_byte(8'h1C);
    tick();
    chk("t4_round", bus_if.round_state, 2'd3);
    chk("t4_foul", bus_if.foul, 1'b1);
    chk("t4_winner", bus_if.winner, 2'd2);
    pulse_clr();
    chk("t4_clr_round", bus_if.round_state, 2'd0);
    chk("t4_clr_foul", bus_if.foul, 1'b0);
    chk("t4_clr_winner", bus_if.winner, 2'd0);

    // typematic suppression and overflow
    do_reset();
    repeat (5) send_byte(8'h1C);
    pop_expect("t5_single", 10'h01C);
    chk("t5_single_empty", bus_if.ev_valid, 1'b0);
    send_byte(8'h15);
    send_byte(8'h24);
    send_byte(8'h2D);
    send_byte(8'h2C);
    chk("t5_not_yet_ovf", bus_if.overflow, 1'b0);
    send_byte(8'h35);
    chk("t5_ovf", bus_if.overflow, 1'b1);
    pop_expect("t5_e0", 10'h015);
    pop_expect("t5_e1", 10'h024);
    pop_expect("t5_e2", 10'h02D);
    pop_expect("t5_e3", 10'h02C);
    chk("t5_drained", bus_if.ev_valid, 1'b0);
    chk("t5_ovf_sticky", bus_if.overflow, 1'b1);
    pulse_clr();
    chk("t5_ovf_clr", bus_if.overflow, 1'b0);

    // prefix timeout exactly at the limit, and one cycle short of it
    do_reset();
    send_byte(8'hF0);
    repeat (TMO) tick();
    send_byte(8'h1C);
    pop_expect("t6_timeout", 10'h01C);
    do_reset();
    send_byte(8'hF0);
    repeat (TMO - 1) tick();
    send_byte(8'h1C);
    pop_expect("t6_short", 10'h11C);

    // frame error aborts the prefix; it also wins over a same-cycle byte
    do_reset();
    send_byte(8'hF0);
    bus_if.frame_err = 1; tick(); bus_if.frame_err = 0;
    send_byte(8'h1C);
    pop_expect("t7_ferr", 10'h01C);
    do_reset();
    bus_if.frame_err = 1; bus_if.byte_valid = 1; bus_if.byte_data = 8'h1C;
    tick();
    idle_inputs();
    chk("t7_both_ev", bus_if.ev_valid, 1'b0);
    chk("t7_both_kd", bus_if.key_down, 3'b000);

    // randomised traffic
    do_reset();
    rdy_pct = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) rdy_pct = $urandom_range(5, 90);
      if (i == 2000) do_reset();
      bus_if.ev_ready   = ($urandom_range(0, 99) < rdy_pct);
      bus_if.byte_valid = ($urandom_range(0, 99) < 40);
      bus_if.byte_data  = pick_byte();
      bus_if.frame_err  = ($urandom_range(0, 99) < 3);
      bus_if.arm        = ($urandom_range(0, 99) < 5);
      bus_if.go         = ($urandom_range(0, 99) < 6);
      bus_if.clr        = ($urandom_range(0, 99) < 2);
      tick();
      if ($urandom_range(0, 99) < 2) begin
        idle_inputs();
        repeat ($urandom_range(TMO - 3, TMO + 3)) tick();
      end
    end
    idle_inputs();
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
